// File: rtl/fmcw_ram_pkg.sv
// rtl/fmcw_ram_pkg.sv - shared types and constants for the single-port RAM arbiter
// Purpose: owner encoding for the arbitration FSM and the fixed read latency
//          seen by the arbiter top level and its users.
package fmcw_ram_pkg;

  typedef enum logic {
    OWN_WR = 1'b0,
    OWN_RD = 1'b1
  } owner_t;

  // Acceptance -> RAM command register -> RAM output (no output register).
  localparam int RAM_READ_LATENCY = 2;

  localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/ram_single_arbiter.sv
// rtl/ram_single_arbiter.sv - burst-limited round-robin arbiter for one single-port block RAM
// Purpose: shares a NO_CHANGE single-port RAM between a write requester and a
//          read requester, one accepted request per cycle, fixed read latency.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data write request handshake
//   rd_valid/rd_ready/rd_addr         read request handshake
//   rd_dvalid/rd_data                 read return, RAM_READ_LATENCY cycles after accept
//   ram_en/ram_we/ram_addr/ram_di     registered command to the RAM macro
//   ram_do                            RAM read data
module ram_single_arbiter
  import fmcw_ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_BURST     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDRESS_WIDTH-1:0]     wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic                         rd_valid,
  output logic                         rd_ready,
  input  logic [ADDRESS_WIDTH-1:0]     rd_addr,
  output logic                         rd_dvalid,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         ram_en,
  output logic                         ram_we,
  output logic [ADDRESS_WIDTH-1:0]     ram_addr,
  output logic signed [DATA_WIDTH-1:0] ram_di,
  input  logic signed [DATA_WIDTH-1:0] ram_do
);

  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);

  owner_t                   owner_q, owner_n;
  logic [BURST_CNT_W-1:0]   burst_q, burst_n;
  logic                     contested;
  logic                     wr_acc, rd_acc;
  logic [RAM_READ_LATENCY-1:0] rd_pipe;

  // Readies depend only on the valids and the registered owner, never on
  // each other. They are held low while reset is asserted so nothing is
  // accepted into a pipeline that is being cleared.
  always_comb begin
    contested = wr_valid && rd_valid;
    wr_ready  = rst_n && wr_valid && (!rd_valid || (owner_q == OWN_WR));
    rd_ready  = rst_n && rd_valid && (!wr_valid || (owner_q == OWN_RD));
    wr_acc    = wr_valid && wr_ready;
    rd_acc    = rd_valid && rd_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_WR;
      burst_q <= '0;
    end else begin
      owner_q <= owner_n;
      burst_q <= burst_n;
    end
  end

  // Under contention the owner is always the one granted, so counting
  // contested grants bounds how long the other side waits.
  always_comb begin
    owner_n = owner_q;
    burst_n = burst_q;
    if (contested) begin
      if (burst_q >= BURST_LAST) begin
        owner_n = (owner_q == OWN_WR) ? OWN_RD : OWN_WR;
        burst_n = '0;
      end else begin
        burst_n = burst_q + 1'b1;
      end
    end else if (wr_acc) begin
      owner_n = OWN_WR;
      burst_n = '0;
    end else if (rd_acc) begin
      owner_n = OWN_RD;
      burst_n = '0;
    end
  end

  // RAM command register. Address/data hold when idle; write data only
  // moves on an accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_di   <= '0;
    end else begin
      ram_en <= wr_acc || rd_acc;
      ram_we <= wr_acc;
      if (wr_acc) begin
        ram_addr <= wr_addr;
        ram_di   <= wr_data;
      end else if (rd_acc) begin
        ram_addr <= rd_addr;
      end
    end
  end

  // Stage 0 marks the cycle the read command sits on the RAM pins; the last
  // stage lines up with ram_do. Reset empties it, dropping in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= {rd_pipe[RAM_READ_LATENCY-2:0], rd_acc};
    end
  end

  assign rd_dvalid = rd_pipe[RAM_READ_LATENCY-1];
  assign rd_data   = ram_do;

endmodule
